dca_matrix_move_controller: RTL



---
 rtl/dca_matrix_move_controller_pkg.sv | 39 +++
 rtl/dca_matrix_row_counter.sv | 37 +++
 rtl/dca_matrix_move_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dca_matrix_move_controller_pkg.sv
// Shared constants and encodings for the DCA matrix row-move sequencer:
// op codes, FSM states and the derived matrix dimensions.
package dca_matrix_move_controller_pkg;

    localparam int MATRIX_SIZE_PARA = 8;
    localparam int BW_TENSOR_SCALAR = 32;

    // Square matrices: the size code is the row and column count.
    localparam int MATRIX_NUM_ROW = MATRIX_SIZE_PARA;
    localparam int MATRIX_NUM_COL = MATRIX_SIZE_PARA;
    localparam int BW_TENSOR_ROW  = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
    localparam int BW_ROW_CNT     = $clog2(MATRIX_NUM_ROW + 1);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Row count requested by a command: 0 and oversize requests mean a full matrix.
    function automatic logic [BW_ROW_CNT-1:0] clamp_rows(input logic [BW_ROW_CNT-1:0] req);
        logic [BW_ROW_CNT-1:0] full;
        full = BW_ROW_CNT'(MATRIX_NUM_ROW);
        if ((req == {BW_ROW_CNT{1'b0}}) || (req > full)) begin
            return full;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/dca_matrix_row_counter.sv
// Row counter with target load, synchronous clear-on-load, increment and a
// terminal flag that is high while the next increment reaches the target.
module dca_matrix_row_counter #(
    parameter int BW_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BW_CNT-1:0] load_tgt,
    input  logic              inc,
    output logic [BW_CNT-1:0] count,
    output logic              terminal
);

    logic [BW_CNT-1:0] count_r;
    logic [BW_CNT-1:0] tgt_r;

    // Count and target registers; load wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {BW_CNT{1'b0}};
            tgt_r   <= {BW_CNT{1'b0}};
        end else if (load) begin
            count_r <= {BW_CNT{1'b0}};
            tgt_r   <= load_tgt;
        end else if (inc) begin
            count_r <= count_r + {{(BW_CNT-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Compare one bit wider so a zero target can never alias to a match.
    assign terminal = (({1'b0, count_r} + {{BW_CNT{1'b0}}, 1'b1}) == {1'b0, tgt_r});
    assign count    = count_r;

endmodule

// File: rtl/dca_matrix_move_controller.sv
// Command sequencer for the row-move port of a DCA matrix register.
// Optional build macro DCA_MATRIX_MOVE_CTRL_RESTORE_EN: STORE writes each read row back (rotate).
module dca_matrix_move_controller
    import dca_matrix_move_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [BW_ROW_CNT-1:0]    cmd_num_rows,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BW_TENSOR_ROW-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [BW_TENSOR_ROW-1:0] m_data,
    output logic                     mreg_init,
    output logic                     mreg_move_wenable,
    output logic                     mreg_move_renable,
    output logic [BW_TENSOR_ROW-1:0] mreg_move_wdata_list,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list,
    output logic                     busy,
    output logic                     done,
    output logic [BW_ROW_CNT-1:0]    row_count
);

    state_e state_r;
    state_e state_nxt_s;
    logic   done_r;
    logic   done_nxt_s;
    logic   accept_s;
    logic   xfer_s;
    logic   terminal_s;
    logic   live_s;

    assign live_s = ~rst;

    // State and completion-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next state and all handshake/strobe outputs; everything is masked while rst is high.
    always_comb begin
        state_nxt_s          = state_r;
        done_nxt_s           = 1'b0;
        accept_s             = 1'b0;
        xfer_s               = 1'b0;
        cmd_ready            = 1'b0;
        s_ready              = 1'b0;
        m_valid              = 1'b0;
        m_data               = {BW_TENSOR_ROW{1'b0}};
        mreg_init            = 1'b0;
        mreg_move_wenable    = 1'b0;
        mreg_move_renable    = 1'b0;
        mreg_move_wdata_list = {BW_TENSOR_ROW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                cmd_ready = live_s;
                accept_s  = cmd_valid & live_s;
                if (accept_s) begin
                    case (cmd_op)
                        OP_LOAD:  state_nxt_s = ST_LOAD;
                        OP_STORE: state_nxt_s = ST_STORE;
                        OP_CLEAR: state_nxt_s = ST_CLEAR;
                        default:  done_nxt_s  = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                s_ready              = live_s;
                xfer_s               = s_valid & live_s;
                mreg_move_wenable    = xfer_s;
                mreg_move_wdata_list = s_data;
                if (xfer_s && terminal_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_STORE: begin
                m_valid           = live_s;
                m_data            = mreg_move_rdata_list;
                xfer_s            = m_ready & live_s;
                mreg_move_renable = xfer_s;
`ifdef DCA_MATRIX_MOVE_CTRL_RESTORE_EN
                mreg_move_wenable    = xfer_s;
                mreg_move_wdata_list = mreg_move_rdata_list;
`endif
                if (xfer_s && terminal_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STORE;
                end
            end
            ST_CLEAR: begin
                mreg_init   = live_s;
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    dca_matrix_row_counter #(
        .BW_CNT (BW_ROW_CNT)
    ) u_row_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_tgt (clamp_rows(cmd_num_rows)),
        .inc      (xfer_s),
        .count    (row_count),
        .terminal (terminal_s)
    );

    assign busy = (state_r != ST_IDLE);
    assign done = done_r;

endmodule
